// File: rtl/shift_seq_if.sv
// Shared types and the control-unit-facing request/response interface of
// the multi-cycle shift sequencer.
package shift_seq_pkg;

  typedef enum logic [3:0] {
    ALU_PASSA = 4'd0,
    ALU_ADD   = 4'd1,
    ALU_SUB   = 4'd2,
    ALU_AND   = 4'd3,
    ALU_OR    = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SHL   = 4'd6,
    ALU_SHR   = 4'd7,
    ALU_ASHR  = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_SHL  = 2'd0,
    SH_SHR  = 2'd1,
    SH_ASHR = 2'd2,
    SH_RSVD = 2'd3
  } shift_kind_e;

endpackage

interface shift_seq_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand;
  logic [AMT_W-1:0] amount;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       status;

  modport master (
    output start, op, operand, amount,
    input  busy, done, result, status
  );

  modport slave (
    input  start, op, operand, amount,
    output busy, done, result, status
  );
endinterface

// File: rtl/shift_seq.sv
// Multi-cycle barrel-shift sequencer: steps the single-bit ALU shifter once per
// cycle, feeding each result back, and reports the final value with NZCV.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_seq_if.slave       req,
  output alu_op_e          alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic             alu_oe,
  input  logic [WIDTH-1:0] alu_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state, state_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [AMT_W-1:0] cnt, cnt_next;
  shift_kind_e      kind, kind_next;
  logic             cbit, cbit_next;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       status_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    kind_next  = kind;
    cbit_next  = cbit;
    alu_oe     = 1'b0;
    alu_op     = ALU_PASSA;

    case (state)
      S_IDLE: begin
        if (req.start) begin
          acc_next   = req.operand;
          cnt_next   = req.amount;
          kind_next  = shift_kind_e'(req.op);
          cbit_next  = 1'b0;
          state_next = (req.amount == '0 || req.op == SH_RSVD) ? S_DONE : S_SHIFT;
        end
      end

      S_SHIFT: begin
        alu_oe = 1'b1;
        case (kind)
          SH_SHL:  alu_op = ALU_SHL;
          SH_SHR:  alu_op = ALU_SHR;
          default: alu_op = ALU_ASHR;
        endcase
        acc_next = alu_out;
        cnt_next = cnt - 1'b1;
        // Carry is derived here: the ALU gives no carry for right shifts.
        cbit_next = (kind == SH_SHL) ? acc[WIDTH-1] : acc[0];
        if (cnt == AMT_W'(1)) state_next = S_DONE;
      end

      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      acc      <= '0;
      cnt      <= '0;
      kind     <= SH_SHL;
      cbit     <= 1'b0;
      result_q <= '0;
      status_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
      kind  <= kind_next;
      cbit  <= cbit_next;
      // Capture on entry to DONE from the value acc is about to take.
      if (state_next == S_DONE) begin
        result_q <= acc_next;
        status_q <= {acc_next[WIDTH-1], (acc_next == '0), cbit_next, 1'b0};
      end
    end
  end

  assign req.busy   = (state != S_IDLE);
  assign req.done   = (state == S_DONE);
  assign req.result = result_q;
  assign req.status = status_q;
  assign alu_a      = acc;

endmodule

// File: tb/tb_shift_seq.sv
// Directed-vector bench for shift_seq with a behavioural single-step ALU.
module tb_shift_seq;
  import shift_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  alu_op_e     alu_op;
  logic [31:0] alu_a;
  logic        alu_oe;
  logic [31:0] alu_out;

  int errors = 0;
  int checks = 0;

  shift_seq_if #(.WIDTH(32), .AMT_W(5)) sif ();

  shift_seq #(.WIDTH(32), .AMT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (sif),
    .alu_op  (alu_op),
    .alu_a   (alu_a),
    .alu_oe  (alu_oe),
    .alu_out (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-step ALU; junk on the bus when not enabled.
  always_comb begin
    alu_out = 32'hDEAD_BEEF;
    if (alu_oe) begin
      case (alu_op)
        ALU_SHL:  alu_out = alu_a << 1;
        ALU_SHR:  alu_out = alu_a >> 1;
        ALU_ASHR: alu_out = {alu_a[31], alu_a[31:1]};
        default:  alu_out = alu_a;
      endcase
    end
  end

  // Issue one request (called just after an edge) and observe until busy drops.
  task automatic run_op(input logic [1:0] o, input logic [31:0] v, input logic [4:0] a,
                        output int done_cyc, output int oe_cnt, output int busy_cnt,
                        output alu_op_e op1, output logic [31:0] a1);
    done_cyc = -1; oe_cnt = 0; busy_cnt = 0; op1 = ALU_PASSA; a1 = '0;
    sif.op = o; sif.operand = v; sif.amount = a; sif.start = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) begin op1 = alu_op; a1 = alu_a; end
      if (sif.busy) busy_cnt++;
      if (alu_oe) oe_cnt++;
      if (sif.done) done_cyc = c;
      if (!sif.busy) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sif.start = 1'b0; sif.op = '0; sif.operand = '0; sif.amount = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (sif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", sif.busy); end
    checks++; if (sif.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", sif.done); end
    checks++; if (alu_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", alu_oe); end
    checks++; if (alu_op !== ALU_PASSA) begin errors++; $display("FAIL reset_op: got %0d expected %0d", alu_op, ALU_PASSA); end
    checks++; if (alu_a !== 32'h0) begin errors++; $display("FAIL reset_a: got %h expected 0", alu_a); end
    checks++; if (sif.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", sif.result); end
    checks++; if (sif.status !== 4'h0) begin errors++; $display("FAIL reset_status: got %b expected 0000", sif.status); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_shl();
    int dc, oc, bc; alu_op_e o1; logic [31:0] a1;
    run_op(2'd0, 32'h8000_0001, 5'd1, dc, oc, bc, o1, a1);
    checks++; if (sif.result !== 32'h0000_0002) begin errors++; $display("FAIL shl_result: got %h expected 00000002", sif.result); end
    checks++; if (sif.status !== 4'b0010) begin errors++; $display("FAIL shl_status: got %b expected 0010", sif.status); end
    checks++; if (dc !== 2) begin errors++; $display("FAIL shl_done_cycle: got %0d expected 2", dc); end
    checks++; if (oc !== 1) begin errors++; $display("FAIL shl_oe_cycles: got %0d expected 1", oc); end
    checks++; if (o1 !== ALU_SHL) begin errors++; $display("FAIL shl_alu_op: got %0d expected %0d", o1, ALU_SHL); end
    checks++; if (a1 !== 32'h8000_0001) begin errors++; $display("FAIL shl_alu_a: got %h expected 80000001", a1); end
    checks++; if (bc !== 2) begin errors++; $display("FAIL shl_busy_cycles: got %0d expected 2", bc); end
  endtask

  task automatic test_shr();
    int dc, oc, bc; alu_op_e o1; logic [31:0] a1;
    run_op(2'd1, 32'h0000_0001, 5'd1, dc, oc, bc, o1, a1);
    checks++; if (sif.result !== 32'h0) begin errors++; $display("FAIL shr_result: got %h expected 00000000", sif.result); end
    checks++; if (sif.status !== 4'b0110) begin errors++; $display("FAIL shr_status: got %b expected 0110", sif.status); end
    checks++; if (dc !== 2) begin errors++; $display("FAIL shr_done_cycle: got %0d expected 2", dc); end
    checks++; if (o1 !== ALU_SHR) begin errors++; $display("FAIL shr_alu_op: got %0d expected %0d", o1, ALU_SHR); end
  endtask

  task automatic test_ashr();
    int dc, oc, bc; alu_op_e o1; logic [31:0] a1;
    run_op(2'd2, 32'h8000_0000, 5'd31, dc, oc, bc, o1, a1);
    checks++; if (sif.result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ashr_result: got %h expected ffffffff", sif.result); end
    checks++; if (sif.status !== 4'b1000) begin errors++; $display("FAIL ashr_status: got %b expected 1000", sif.status); end
    checks++; if (dc !== 32) begin errors++; $display("FAIL ashr_done_cycle: got %0d expected 32", dc); end
    checks++; if (bc !== 32) begin errors++; $display("FAIL ashr_busy_cycles: got %0d expected 32", bc); end
    checks++; if (oc !== 31) begin errors++; $display("FAIL ashr_oe_cycles: got %0d expected 31", oc); end
  endtask

  task automatic test_pass();
    int dc, oc, bc; alu_op_e o1; logic [31:0] a1;
    run_op(2'd0, 32'h1234_5678, 5'd0, dc, oc, bc, o1, a1);
    checks++; if (sif.result !== 32'h1234_5678) begin errors++; $display("FAIL pass0_result: got %h expected 12345678", sif.result); end
    checks++; if (sif.status !== 4'b0000) begin errors++; $display("FAIL pass0_status: got %b expected 0000", sif.status); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL pass0_done_cycle: got %0d expected 1", dc); end
    checks++; if (oc !== 0) begin errors++; $display("FAIL pass0_oe_cycles: got %0d expected 0", oc); end
    run_op(2'd3, 32'h1234_5678, 5'd5, dc, oc, bc, o1, a1);
    checks++; if (sif.result !== 32'h1234_5678) begin errors++; $display("FAIL pass3_result: got %h expected 12345678", sif.result); end
    checks++; if (sif.status !== 4'b0000) begin errors++; $display("FAIL pass3_status: got %b expected 0000", sif.status); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL pass3_done_cycle: got %0d expected 1", dc); end
    checks++; if (oc !== 0) begin errors++; $display("FAIL pass3_oe_cycles: got %0d expected 0", oc); end
  endtask

  task automatic test_collision();
    sif.op = 2'd0; sif.operand = 32'h1; sif.amount = 5'd4; sif.start = 1'b1;
    @(posedge clk); #1; sif.start = 1'b0;                      // cycle 1
    @(posedge clk); #1;                                        // cycle 2
    sif.op = 2'd1; sif.operand = 32'hFFFF_0000; sif.amount = 5'd1; sif.start = 1'b1;
    @(posedge clk); #1; sif.start = 1'b0;                      // cycle 3
    @(posedge clk); #1;                                        // cycle 4
    checks++; if (sif.done !== 1'b0) begin errors++; $display("FAIL coll_early_done: got %b expected 0", sif.done); end
    @(posedge clk); #1;                                        // cycle 5 (DONE)
    checks++; if (sif.done !== 1'b1) begin errors++; $display("FAIL coll_done: got %b expected 1", sif.done); end
    checks++; if (sif.result !== 32'h10) begin errors++; $display("FAIL coll_result: got %h expected 00000010", sif.result); end
    checks++; if (sif.status !== 4'b0000) begin errors++; $display("FAIL coll_status: got %b expected 0000", sif.status); end
    sif.op = 2'd2; sif.operand = 32'hAAAA_AAAA; sif.amount = 5'd7; sif.start = 1'b1;
    @(posedge clk); #1;                                        // cycle 6
    checks++; if (sif.busy !== 1'b0) begin errors++; $display("FAIL coll_done_start_taken: busy got %b expected 0", sif.busy); end
    checks++; if (sif.result !== 32'h10) begin errors++; $display("FAIL coll_result_hold: got %h expected 00000010", sif.result); end
    sif.op = 2'd1; sif.operand = 32'h3; sif.amount = 5'd1; sif.start = 1'b1;
    @(posedge clk); #1; sif.start = 1'b0;                      // cycle 7
    checks++; if (sif.busy !== 1'b1 || alu_oe !== 1'b1) begin errors++; $display("FAIL coll_accept: busy/oe got %b%b expected 11", sif.busy, alu_oe); end
    checks++; if (alu_a !== 32'h3) begin errors++; $display("FAIL coll_accept_a: got %h expected 00000003", alu_a); end
    @(posedge clk); #1;                                        // cycle 8
    checks++; if (sif.done !== 1'b1 || sif.result !== 32'h1) begin errors++; $display("FAIL coll_second: done/result got %b/%h expected 1/00000001", sif.done, sif.result); end
    checks++; if (sif.status !== 4'b0010) begin errors++; $display("FAIL coll_second_status: got %b expected 0010", sif.status); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int dc, oc, bc; alu_op_e o1; logic [31:0] a1;
    run_op(2'd0, 32'h4000_0000, 5'd2, dc, oc, bc, o1, a1);
    checks++; if (sif.result !== 32'h0 || sif.status !== 4'b0110) begin errors++; $display("FAIL b2b_first: result/status got %h/%b expected 00000000/0110", sif.result, sif.status); end
    checks++; if (dc !== 3) begin errors++; $display("FAIL b2b_first_done_cycle: got %0d expected 3", dc); end
    run_op(2'd2, 32'hF000_0000, 5'd4, dc, oc, bc, o1, a1);
    checks++; if (sif.result !== 32'hFF00_0000) begin errors++; $display("FAIL b2b_second_result: got %h expected ff000000", sif.result); end
    checks++; if (sif.status !== 4'b1000) begin errors++; $display("FAIL b2b_second_status: got %b expected 1000", sif.status); end
    checks++; if (dc !== 5) begin errors++; $display("FAIL b2b_second_done_cycle: got %0d expected 5", dc); end
    checks++; if (o1 !== ALU_ASHR) begin errors++; $display("FAIL b2b_second_op: got %0d expected %0d", o1, ALU_ASHR); end
  endtask

  task automatic test_reset_mid();
    int dc, oc, bc; alu_op_e o1; logic [31:0] a1;
    sif.op = 2'd0; sif.operand = 32'h1; sif.amount = 5'd10; sif.start = 1'b1;
    @(posedge clk); #1; sif.start = 1'b0;                      // cycle 1
    @(posedge clk); #1;                                        // cycle 2
    @(posedge clk); #1;                                        // cycle 3
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sif.busy !== 1'b0 || sif.done !== 1'b0) begin errors++; $display("FAIL mid_busy_done: got %b%b expected 00", sif.busy, sif.done); end
    checks++; if (alu_oe !== 1'b0) begin errors++; $display("FAIL mid_oe: got %b expected 0", alu_oe); end
    checks++; if (alu_op !== ALU_PASSA) begin errors++; $display("FAIL mid_op: got %0d expected %0d", alu_op, ALU_PASSA); end
    checks++; if (alu_a !== 32'h0) begin errors++; $display("FAIL mid_a: got %h expected 0", alu_a); end
    checks++; if (sif.result !== 32'h0) begin errors++; $display("FAIL mid_result: got %h expected 0", sif.result); end
    checks++; if (sif.status !== 4'h0) begin errors++; $display("FAIL mid_status: got %b expected 0000", sif.status); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (sif.done !== 1'b0) begin errors++; $display("FAIL mid_no_done: got %b expected 0", sif.done); end
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (sif.done !== 1'b0 || sif.busy !== 1'b0) begin errors++; $display("FAIL mid_after_release: got %b%b expected 00", sif.busy, sif.done); end
    run_op(2'd1, 32'h0000_00F8, 5'd4, dc, oc, bc, o1, a1);
    checks++; if (sif.result !== 32'hF) begin errors++; $display("FAIL mid_next_result: got %h expected 0000000f", sif.result); end
    checks++; if (sif.status !== 4'b0010) begin errors++; $display("FAIL mid_next_status: got %b expected 0010", sif.status); end
    checks++; if (dc !== 5) begin errors++; $display("FAIL mid_next_done_cycle: got %0d expected 5", dc); end
  endtask

  initial begin
    test_reset();
    test_shl();
    test_shr();
    test_ashr();
    test_pass();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle barrel-shift sequencer that drives the single-step ALU as its initiator. It accepts a shift request of 0–31 bit positions and issues one ALU shift operation per cycle, feeding each ALU result back as the next operand. It returns the final value plus NZCV flags through a start/busy/done handshake. It sits between the control unit and the ALU and owns the ALU's `operation`, `a` and `oe` inputs while busy.

## Interface
- `WIDTH`, 32, datapath width; must match the ALU.
- `AMT_W`, 5, shift-amount width; amounts run from 0 to 2^AMT_W−1.

- `clk` in 1 — single clock; all state changes on its rising edge.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `start` in 1 — request strobe; sampled only when `busy`=0.
- `op` in 2 — shift kind: 0=SHL, 1=SHR (logical), 2=ASHR, 3=reserved.
- `operand` in WIDTH — value to shift; latched on an accepted start.
- `amount` in AMT_W — number of single-bit steps; latched on an accepted start.
- `busy` out 1 — high from the cycle after an accepted start through the done cycle, inclusive.
- `done` out 1 — one-cycle pulse marking `result`/`status` valid.
- `result` out WIDTH — final shifted value; holds until the next accepted start.
- `status` out 4 — {N,Z,C,V} of the final result; holds with `result`.
- `alu_op` out alu_op_e — operation presented to the ALU.
- `alu_a` out WIDTH — ALU `a` operand; always equals the internal accumulator.
- `alu_oe` out 1 — ALU output enable.
- `alu_out` in WIDTH — ALU result bus, read only while `alu_oe`=1.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `start`=1 latches `operand` into `acc`, `amount` into `cnt`, and `op` into `kind`.
  - If `amount`=0 or `op`=3, go to DONE. Otherwise go to SHIFT.
- SHIFT:
  - Drive `alu_oe`=1 and `alu_op` = SHL, SHR or ASHR per `kind`.
  - Each edge: `acc`<=`alu_out`, `cnt`<=`cnt`−1, `cbit`<=bit shifted out. The shifted-out bit is `acc[WIDTH-1]` for SHL and `acc[0]` for SHR/ASHR.
  - When `cnt`=1 at the edge, go to DONE.
- DONE:
  - `result`<=`acc` (registered on entry).
  - `status`: N=`acc[WIDTH-1]`, Z=(`acc`==0), C=`cbit`, V=0.
  - `done`=1 for exactly this cycle; next state is IDLE.
- Outside SHIFT: `alu_oe`=0 and `alu_op`=PASSA.
- The C flag is computed inside this block. It does not use the ALU carry, because the ALU produces no carry for right shifts.
- For pass-through requests (amount 0 or op 3), `cbit`=0, so C=0.
- `start` is ignored whenever `busy`=1, including in the DONE cycle. It is not queued.
- `cnt` never wraps: it is loaded only with a nonzero value before SHIFT and leaves SHIFT on reaching 1.

## Timing
- Reset (any time, including mid-SHIFT) takes effect immediately:
  - State goes to IDLE.
  - `busy`=0, `done`=0, `alu_oe`=0, `alu_op`=PASSA.
  - `acc`, `alu_a`, `result` and `status` all go to 0; `cnt`=0.
  - No partial result is delivered.
- The edge that samples `start` is edge 0.
  - SHIFT occupies cycles 1..amount.
  - `done` is high in cycle amount+1, and `busy` falls after it.
  - Amount 0: `done` is high in cycle 1.
- A new `start` may be accepted in the cycle after `done`, giving back-to-back throughput of amount+2 cycles.
- The ALU path is combinational within one cycle: `alu_a`/`alu_op` are registered here, and `alu_out` is captured at the same cycle's edge.
- `result` and `status` update only on entry to DONE. They are stable at all other times.

## Test plan
- SHL: `operand`=0x8000_0001, `amount`=1 → `result`=0x0000_0002, NZCV=0010. `done` in cycle 2; `alu_oe` high in cycle 1 only.
- SHR: `operand`=0x0000_0001, `amount`=1 → `result`=0, NZCV=0110.
- ASHR: `operand`=0x8000_0000, `amount`=31 → `result`=0xFFFF_FFFF, NZCV=1000. `busy` high for 32 cycles; `done` in cycle 32.
- Pass-through: `amount`=0 with `operand`=0x1234_5678; then `op`=3 with `amount`=5 → both give `result`=0x1234_5678, NZCV=0000, `done` in cycle 1, and `alu_oe` never high.
- Collision: SHL of 0x1 by 4, with `start` pulsed again in cycles 2 and 5 (DONE) → second request ignored, `result`=0x10. A `start` in cycle 6 is accepted.
- Reset mid-op: deassert `rst_n` in cycle 3 of a 10-step shift → all outputs 0 asynchronously, no `done` pulse. The next request completes normally.
